sum_accum: RTL and testbench

Downstream consumer of the `fsm` block's 4-bit output `w`. It adds each new `w` value into a saturating decimal running total (0–999). It then converts the total to three BCD digits with a sequential double-dabble engine, for the display stage. Accumulation and conversion run concurrently, and a conversion request that arrives while the engine is busy is kept and serviced, never dropped.

---
 rtl/sum_pkg.sv | 16 +
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/sum_accum.sv | 82 ++++++++
 tb/tb_sum_accum.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared types and constants for the running-total / BCD display path.
// The converter state enum lives here so the display stage can decode it too.
package sum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } conv_state_t;

    localparam int TOTAL_W    = 10;
    localparam int BCD_W      = 12;
    localparam int SAT_MAX    = 999;
    localparam int CONV_ITERS = 10;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle over BIN_W
// iterations, followed by a single DONE cycle that publishes the result.
module bin2bcd_seq #(
    parameter int BIN_W = sum_pkg::TOTAL_W,
    parameter int BCD_W = sum_pkg::BCD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    import sum_pkg::*;

    localparam int SR_W  = BCD_W + BIN_W;
    localparam int NDIG  = BCD_W / 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             done_q, done_d;

    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_step;

    // Add-3 correction on every BCD digit that would overflow on the next shift.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_adj
            assign sr_adj[BIN_W + gi*4 +: 4] = (sr_q[BIN_W + gi*4 +: 4] >= 4'd5)
                                             ? sr_q[BIN_W + gi*4 +: 4] + 4'd3
                                             : sr_q[BIN_W + gi*4 +: 4];
        end
    endgenerate

    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
    assign sr_step           = sr_adj << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, din};
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = sr_q[SR_W-1:BIN_W];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/sum_accum.sv
// Saturating running total of the fsm's w output, with a background BCD conversion
// that is re-requested on every total update and never loses a request.
module sum_accum #(
    parameter int TOTAL_W = sum_pkg::TOTAL_W,
    parameter int SAT_MAX = sum_pkg::SAT_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         w,
    input  logic               clr,
    output logic [TOTAL_W-1:0] total,
    output logic [11:0]        bcd,
    output logic               bcd_valid,
    output logic               busy
);
    import sum_pkg::*;

    localparam logic [TOTAL_W:0]   SAT_WIDE   = (TOTAL_W + 1)'(SAT_MAX);
    localparam logic [TOTAL_W-1:0] SAT_NARROW = TOTAL_W'(SAT_MAX);

    logic [3:0]         w_prev_q, w_prev_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               pending_q, pending_d;

    logic               changed;
    logic               update;
    logic [TOTAL_W:0]   sum_wide;
    logic               conv_busy;
    logic               conv_ack;

    assign changed  = (w != w_prev_q);
    assign update   = clr || changed;
    // One extra bit so the saturation compare can never be fooled by a wrap.
    assign sum_wide = {1'b0, total_q} + (TOTAL_W + 1)'(w);
    assign conv_ack = pending_q && !conv_busy;

    always_comb begin
        w_prev_d  = w;
        total_d   = total_q;
        pending_d = pending_q;
        if (clr) begin
            total_d = '0;
        end else if (changed) begin
            total_d = (sum_wide > SAT_WIDE) ? SAT_NARROW : sum_wide[TOTAL_W-1:0];
        end
        // A fresh update wins over the converter consuming the older request.
        if (update) begin
            pending_d = 1'b1;
        end else if (conv_ack) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_prev_q  <= '0;
            total_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            w_prev_q  <= w_prev_d;
            total_q   <= total_d;
            pending_q <= pending_d;
        end
    end

    bin2bcd_seq #(
        .BIN_W (TOTAL_W),
        .BCD_W (BCD_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (pending_q),
        .din   (total_q),
        .busy  (conv_busy),
        .done  (bcd_valid),
        .bcd   (bcd)
    );

    assign total = total_q;
    assign busy  = conv_busy;

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: directed table, hand-written corner sequences
// and a randomized run, all compared against a behavioural reference model.
module tb_sum_accum;

    logic        clk;
    logic        reset;
    logic [3:0]  w;
    logic        clr;
    logic [9:0]  total;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;

    sum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .w         (w),
        .clr       (clr),
        .total     (total),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: a conversion is just "snapshot + countdown to publish".
    int m_total, m_wprev, m_snap, m_cnt, m_bcd;
    bit m_pend, m_valid;

    int pulse_cnt, first_pulse, last_pulse;

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit started;
        bit upd;
        if (!reset) begin
            m_total = 0; m_wprev = 0; m_snap = 0; m_cnt = 0; m_bcd = 0;
            m_pend = 0; m_valid = 0;
        end else begin
            started = 0;
            m_valid = 0;
            if (m_cnt == 0) begin
                if (m_pend) begin
                    m_snap  = m_total;
                    m_cnt   = 11;
                    started = 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1;
                    m_bcd   = to_bcd(m_snap);
                end
            end
            upd = clr || (int'(w) != m_wprev);
            if (clr) m_total = 0;
            else if (int'(w) != m_wprev) m_total = (m_total + int'(w) > 999) ? 999 : m_total + int'(w);
            if (upd) m_pend = 1;
            else if (started) m_pend = 0;
            m_wprev = int'(w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (bcd_valid) begin
            if (pulse_cnt == 0) first_pulse = cyc;
            last_pulse = cyc;
            pulse_cnt++;
        end
        chk("model_total", int'(total), m_total);
        chk("model_bcd", int'(bcd), m_bcd);
        chk("model_valid", int'(bcd_valid), int'(m_valid));
        chk("model_busy", int'(busy), int'(m_cnt != 0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0; w = 4'h0; clr = 1'b0;
        steps(2);
        reset = 1'b1;
        pulse_cnt = 0; first_pulse = -1; last_pulse = -1;
    endtask

    typedef struct {
        logic [3:0] w;
        logic       clr;
        int         exp_total;
    } vec_t;

    vec_t vecs [10];
    int   k0;

    initial begin
        reset = 1'b0; w = 4'hF; clr = 1'b0;
        pulse_cnt = 0; first_pulse = -1; last_pulse = -1;

        // Reset held with w=F, then released with w=0: nothing accepted.
        steps(3);
        chk("rst_total", int'(total), 0);
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(bcd_valid), 0);
        reset = 1'b1; w = 4'h0;
        steps(15);
        chk("rst_release_total", int'(total), 0);
        chk("rst_release_pulses", pulse_cnt, 0);
        $display("reset: total=%0d bcd=%03h busy=%0b", total, bcd, busy);

        // Directed table: accumulation, hold, return-to-value, clear priority.
        vecs[0] = '{4'd1,  1'b0, 1};
        vecs[1] = '{4'd2,  1'b0, 3};
        vecs[2] = '{4'd3,  1'b0, 6};
        vecs[3] = '{4'd3,  1'b0, 6};
        vecs[4] = '{4'd0,  1'b0, 6};
        vecs[5] = '{4'd3,  1'b0, 9};
        vecs[6] = '{4'd15, 1'b1, 0};
        vecs[7] = '{4'd15, 1'b0, 0};
        vecs[8] = '{4'd9,  1'b0, 9};
        vecs[9] = '{4'd4,  1'b0, 13};
        do_reset();
        k0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            w = vecs[i].w; clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_total", i), int'(total), vecs[i].exp_total);
            $display("vec %0d: w=%0d clr=%0b total=%0d", i, vecs[i].w, vecs[i].clr, total);
        end
        clr = 1'b0;
        steps(40);
        chk("seq_first_pulse_latency", first_pulse - k0, 12);
        chk("seq_final_bcd", int'(bcd), 12'h013);

        // Hold: one value held for 20 cycles adds once and converts once.
        do_reset();
        w = 4'd5;
        steps(20);
        chk("hold_total", int'(total), 5);
        chk("hold_pulses", pulse_cnt, 1);
        chk("hold_bcd", int'(bcd), 12'h005);
        $display("hold: total=%0d pulses=%0d bcd=%03h", total, pulse_cnt, bcd);

        // Saturation: 34 pairs of 15/14 reach 986, then clamp at 999.
        do_reset();
        for (int i = 0; i < 34; i++) begin
            w = 4'd15; step();
            w = 4'd14; step();
        end
        chk("sat_pre_total", int'(total), 986);
        w = 4'd15; step();
        chk("sat_clamp_total", int'(total), 999);
        w = 4'd14; step();
        w = 4'd15; step();
        chk("sat_hold_total", int'(total), 999);
        steps(30);
        chk("sat_bcd", int'(bcd), 12'h999);
        $display("saturation: total=%0d bcd=%03h", total, bcd);

        // Change while converting: two pulses 12 cycles apart, second with new total.
        do_reset();
        w = 4'd1; step();
        steps(3);
        chk("ovl_busy_mid", int'(busy), 1);
        w = 4'd2; step();
        steps(30);
        chk("ovl_pulses", pulse_cnt, 2);
        chk("ovl_spacing", last_pulse - first_pulse, 12);
        chk("ovl_bcd", int'(bcd), 12'h003);
        w = 4'd7; clr = 1'b1; step();
        chk("clr_total", int'(total), 0);
        clr = 1'b0; step();
        chk("clr_hold_total", int'(total), 0);
        steps(30);
        chk("clr_bcd", int'(bcd), 12'h000);
        $display("overlap+clr: pulses=%0d total=%0d bcd=%03h", pulse_cnt, total, bcd);

        // Reset during CONVERT kills the conversion and any request.
        do_reset();
        w = 4'd4; step();
        steps(4);
        chk("rmid_busy_before", int'(busy), 1);
        reset = 1'b0; w = 4'd0; step();
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_bcd", int'(bcd), 0);
        reset = 1'b1;
        pulse_cnt = 0;
        steps(20);
        chk("rmid_pulses", pulse_cnt, 0);
        $display("reset mid-conversion: busy=%0b bcd=%03h pulses=%0d", busy, bcd, pulse_cnt);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) w = 4'($urandom_range(0, 15));
            clr   = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        $display("random: %0d cycles, final total=%0d bcd=%03h", 3000, total, bcd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
